// File: rtl/spi_flash_responder_if.sv
// SPI bus bundle between the CPU-side SPI master and the flash responder.
//   spi_cs      : chip select, active-low (master -> slave)
//   spi_sclk    : SPI clock, mode 0 (master -> slave)
//   spi_mosi    : master-to-slave data
//   spi_miso    : slave-to-master data
//   spi_miso_oe : output enable for spi_miso (slave -> pad)
interface spi_flash_responder_if;
  logic spi_cs;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_cs,
    output spi_sclk,
    output spi_mosi,
    input  spi_miso,
    input  spi_miso_oe
  );

  modport slave (
    input  spi_cs,
    input  spi_sclk,
    input  spi_mosi,
    output spi_miso,
    output spi_miso_oe
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI flash emulator feeding the instruction fetch unit. Accepts mode-0 read
// command 0x03 + 16-bit word address and streams 16-bit words MSB-first with
// address auto-increment (wrapping). Storage is preloaded through a parallel
// load port.
// Optional feature macro: SPI_RESP_WRITE_EN enables command 0x02 (word write
// with auto-increment); without it 0x02 is an unsupported command.
// Ports:
//   clk, rst_n        : system clock, synchronous active-low reset
//   spi               : SPI bus (slave modport: cs/sclk/mosi in, miso/miso_oe out)
//   load_en/addr/data : parallel preload port, wins over SPI writes
//   busy              : registered copy of synchronized chip select (active)
//   cmd_err           : one-clk pulse on an unsupported command byte
module spi_flash_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_flash_responder_if.slave spi,
  input  logic                 load_en,
  input  logic [ADDR_W-1:0]    load_addr,
  input  logic [15:0]          load_data,
  output logic                 busy,
  output logic                 cmd_err
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 5;
  localparam logic [7:0]  CMD_READ  = 8'h03;
`ifdef SPI_RESP_WRITE_EN
  localparam logic [7:0]  CMD_WRITE = 8'h02;
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CMD        = 3'd1,
    ADDR       = 3'd2,
    READ_DATA  = 3'd3,
    IGNORE     = 3'd4
`ifdef SPI_RESP_WRITE_EN
    , WRITE_DATA = 3'd5
`endif
  } state_t;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-2:0]   rx_sh;
  logic [WORD_W-1:0]   rx_next;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-1:0]   tx_sh;
  logic [WORD_W-1:0]   hold;
  logic                ld_pend;
  logic                pf_pend;
  logic                miso_q;
  logic                oe_q;
`ifdef SPI_RESP_WRITE_EN
  logic                is_wr;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;
`endif

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign rx_next   = {rx_sh, mosi_s};

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;

  // Address bits above ADDR_W are received but deliberately ignored.
  if (ADDR_W < WORD_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^rx_next[WORD_W-1:ADDR_W];
  end

  // Input synchronizers; cs resets deasserted so no transaction starts in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      sclk_prev <= sclk_s;
    end
  end

  // Protocol FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      addr    <= '0;
      tx_sh   <= '0;
      hold    <= '0;
      ld_pend <= 1'b0;
      pf_pend <= 1'b0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      busy    <= 1'b0;
      cmd_err <= 1'b0;
`ifdef SPI_RESP_WRITE_EN
      is_wr   <= 1'b0;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
`endif
    end else begin
      busy    <= ~cs_s;
      cmd_err <= 1'b0;
`ifdef SPI_RESP_WRITE_EN
      wr_req  <= 1'b0;
`endif
      // Word fetch into the shift register, then prefetch of the following word.
      if (ld_pend) begin
        tx_sh   <= mem[addr];
        ld_pend <= 1'b0;
        pf_pend <= 1'b1;
      end
      if (pf_pend) begin
        hold    <= mem[addr + ADDR_W'(1)];
        pf_pend <= 1'b0;
      end

      if (cs_s) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso_q  <= 1'b0;
        oe_q    <= 1'b0;
        ld_pend <= 1'b0;
        pf_pend <= 1'b0;
`ifdef SPI_RESP_WRITE_EN
        is_wr   <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
          end
          CMD: begin
            if (sclk_rise) begin
              rx_sh <= rx_next[WORD_W-2:0];
              if (bit_cnt == CNT_W'(7)) begin
                bit_cnt <= '0;
                if (rx_next[7:0] == CMD_READ) begin
                  state <= ADDR;
                end
`ifdef SPI_RESP_WRITE_EN
                else if (rx_next[7:0] == CMD_WRITE) begin
                  state <= ADDR;
                  is_wr <= 1'b1;
                end
`endif
                else begin
                  state   <= IGNORE;
                  cmd_err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ADDR: begin
            if (sclk_rise) begin
              rx_sh <= rx_next[WORD_W-2:0];
              if (bit_cnt == CNT_W'(15)) begin
                bit_cnt <= '0;
                addr    <= rx_next[ADDR_W-1:0];
`ifdef SPI_RESP_WRITE_EN
                if (is_wr) begin
                  state <= WRITE_DATA;
                end else
`endif
                begin
                  state   <= READ_DATA;
                  ld_pend <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          READ_DATA: begin
            // bit_cnt counts bits already driven from the current word.
            if (sclk_fall) begin
              oe_q <= 1'b1;
              if (bit_cnt == CNT_W'(16)) begin
                miso_q  <= hold[WORD_W-1];
                tx_sh   <= {hold[WORD_W-2:0], 1'b0};
                bit_cnt <= CNT_W'(1);
                addr    <= addr + ADDR_W'(1);
                pf_pend <= 1'b1;
              end else begin
                miso_q  <= tx_sh[WORD_W-1];
                tx_sh   <= {tx_sh[WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
`ifdef SPI_RESP_WRITE_EN
          WRITE_DATA: begin
            if (sclk_rise) begin
              rx_sh <= rx_next[WORD_W-2:0];
              if (bit_cnt == CNT_W'(15)) begin
                bit_cnt <= '0;
                wr_req  <= 1'b1;
                wr_addr <= addr;
                wr_data <= rx_next;
                addr    <= addr + ADDR_W'(1);
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
`endif
          IGNORE: begin
            miso_q <= 1'b0;
            oe_q   <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Word array, not reset; the load port has priority over SPI writes.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
`ifdef SPI_RESP_WRITE_EN
    else if (wr_req) begin
      mem[wr_addr] <= wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: random preload and random
// reads against an array model, plus the directed corner cases (wrap, bad
// command, aborted address, reset mid-stream, write command).
module tb_spi_flash_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned HALF   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic              busy;
  logic              cmd_err;

  always #5 clk = ~clk;

  spi_flash_responder_if spi_bus ();

  spi_flash_responder #(
    .ADDR_W      (ADDR_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  logic [15:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  int cmd_err_total  = 0;
  int cmd_err_run    = 0;
  int cmd_err_maxrun = 0;
  int oe_cycles      = 0;
  int miso_stray     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pulse widths, oe activity, miso driven while disabled.
  always @(negedge clk) begin
    if (cmd_err === 1'b1) begin
      cmd_err_total++;
      cmd_err_run++;
      if (cmd_err_run > cmd_err_maxrun) cmd_err_maxrun = cmd_err_run;
    end else begin
      cmd_err_run = 0;
    end
    if (spi_bus.spi_miso_oe === 1'b1) oe_cycles++;
    else if (spi_bus.spi_miso !== 1'b0) miso_stray++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_word(input int a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = d;
    wait_clk(1);
    load_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  // One mode-0 bit: master samples miso just before the rising edge.
  task automatic xfer_bit(input logic mo, output logic mi, output logic oe);
    spi_bus.spi_mosi = mo;
    wait_clk(HALF);
    mi = spi_bus.spi_miso;
    oe = spi_bus.spi_miso_oe;
    spi_bus.spi_sclk = 1'b1;
    wait_clk(HALF);
    spi_bus.spi_sclk = 1'b0;
  endtask

  task automatic xfer_n(input int n, input logic [15:0] mo, output logic [15:0] mi, output int oe_hi);
    logic b, o;
    mi = '0;
    oe_hi = 0;
    for (int i = n - 1; i >= 0; i--) begin
      xfer_bit(mo[i], b, o);
      mi[i] = b;
      if (o) oe_hi++;
    end
  endtask

  task automatic cs_low();
    spi_bus.spi_cs = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_bus.spi_cs = 1'b1;
    wait_clk(8);
  endtask

  task automatic do_read(input logic [15:0] a, input int nw, input string tag);
    logic [15:0] rx;
    int oe_hi, oe_pre;
    int ce0;
    ce0 = cmd_err_total;
    cs_low();
    check({tag, " busy_hi"}, 32'(busy), 32'd1);
    xfer_n(8, 16'h0003, rx, oe_hi);
    oe_pre = oe_hi;
    xfer_n(16, a, rx, oe_hi);
    oe_pre += oe_hi;
    check({tag, " oe_pre_data"}, 32'(oe_pre), 32'd0);
    for (int w = 0; w < nw; w++) begin
      xfer_n(16, 16'h0000, rx, oe_hi);
      check($sformatf("%s word%0d", tag, w), 32'(rx),
            32'(ref_mem[(int'(a) + w) % DEPTH]));
      check($sformatf("%s oe%0d", tag, w), 32'(oe_hi), 32'd16);
    end
    cs_high();
    check({tag, " busy_lo"}, 32'(busy), 32'd0);
    check({tag, " oe_off"}, 32'(spi_bus.spi_miso_oe), 32'd0);
    check({tag, " no_cmd_err"}, 32'(cmd_err_total - ce0), 32'd0);
  endtask

  initial begin
    logic [15:0] rx;
    int oe_hi, ce0, oe0, miso_hi;
    logic b, o;

    rst_n            = 1'b0;
    load_en          = 1'b0;
    load_addr        = '0;
    load_data        = '0;
    spi_bus.spi_cs   = 1'b1;
    spi_bus.spi_sclk = 1'b0;
    spi_bus.spi_mosi = 1'b0;
    wait_clk(4);
    check("rst miso", 32'(spi_bus.spi_miso), 32'd0);
    check("rst oe", 32'(spi_bus.spi_miso_oe), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst cmd_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));

    // Basic two-word stream.
    load_word(0, 16'h620A);
    load_word(1, 16'h6414);
    do_read(16'h0000, 2, "rd0");

    // Upper address bits ignored, wrap from top of array.
    load_word(8'hFF, 16'h9FFF);
    do_read(16'h12FF, 2, "wrap");

    // Unsupported command: single pulse, bus stays quiet.
    ce0 = cmd_err_total;
    oe0 = oe_cycles;
    miso_hi = 0;
    cs_low();
    xfer_n(8, 16'h009F, rx, oe_hi);
    for (int i = 0; i < 24; i++) begin
      xfer_bit(1'($urandom), b, o);
      if (b !== 1'b0) miso_hi++;
    end
    cs_high();
    check("bad_cmd pulses", 32'(cmd_err_total - ce0), 32'd1);
    check("bad_cmd oe", 32'(oe_cycles - oe0), 32'd0);
    check("bad_cmd miso", 32'(miso_hi), 32'd0);
    do_read(16'h0000, 1, "after_bad");

    // Abort during address phase.
    cs_low();
    xfer_n(8, 16'h0003, rx, oe_hi);
    xfer_n(10, 16'h03FF, rx, oe_hi);
    cs_high();
    do_read(16'h0001, 1, "after_abort");

    // Reset during the 5th data bit.
    cs_low();
    xfer_n(8, 16'h0003, rx, oe_hi);
    xfer_n(16, 16'h0000, rx, oe_hi);
    xfer_n(4, 16'h0000, rx, oe_hi);
    check("pre_rst nibble", 32'(rx[3:0]), 32'(ref_mem[0][15:12]));
    wait_clk(HALF);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst miso", 32'(spi_bus.spi_miso), 32'd0);
    check("mid_rst oe", 32'(spi_bus.spi_miso_oe), 32'd0);
    check("mid_rst busy", 32'(busy), 32'd0);
    check("mid_rst cmd_err", 32'(cmd_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spi_bus.spi_cs = 1'b1;
    wait_clk(10);
    do_read(16'h0000, 2, "after_rst");

    // Write command.
    ce0 = cmd_err_total;
    cs_low();
    xfer_n(8, 16'h0002, rx, oe_hi);
    xfer_n(16, 16'h0005, rx, oe_hi);
    xfer_n(16, 16'hABCD, rx, oe_hi);
    xfer_n(16, 16'h1234, rx, oe_hi);
    cs_high();
`ifdef SPI_RESP_WRITE_EN
    ref_mem[5] = 16'hABCD;
    ref_mem[6] = 16'h1234;
    check("wr no_cmd_err", 32'(cmd_err_total - ce0), 32'd0);
`else
    check("wr cmd_err", 32'(cmd_err_total - ce0), 32'd1);
`endif
    do_read(16'h0005, 2, "wr_readback");

    // Random reads against the array model.
    for (int t = 0; t < 6; t++) begin
      do_read(16'($urandom), int'($urandom_range(1, 4)), $sformatf("rnd%0d", t));
    end

    check("cmd_err width", 32'(cmd_err_maxrun), 32'd1);
    check("miso stray", 32'(miso_stray), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
